pmem_arbiter_rr: RTL and testbench
==================================

# pmem_arbiter_rr

Parametrised N-port arbiter between the L1 caches (or any line-granular requesters) and a single physical memory or L2 port. It generalises the fixed two-port instruction/data arbiter to NUM_PORTS requesters, with configurable address and line widths and a selectable round-robin or fixed-priority grant policy. It sits between the cache `pmem_*` outputs and the top-level `pmem_*` pins, and is transparent to both sides apart from arbitration latency.

## Interface
- NUM_PORTS, 2: number of requesters; legal range 2..8.
- ADDR_W, 16: physical line address width.
- LINE_W, 128: line data width.
- POLICY, 0: grant policy. 0 = round-robin. 1 = fixed priority, lowest index wins.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_read  in  NUM_PORTS  per-port line read request.
- req_write  in  NUM_PORTS  per-port line write request.
- req_address  in  NUM_PORTS*ADDR_W  packed per-port address; port i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_PORTS*LINE_W  packed per-port write line, packed the same way.
- req_resp  out  NUM_PORTS  per-port completion pulse.
- req_rdata  out  LINE_W  read line, broadcast to all ports.
- pmem_resp  in  1  downstream completion.
- pmem_rdata  in  LINE_W  downstream read line.
- pmem_read  out  1  downstream read.
- pmem_write  out  1  downstream write.
- pmem_address  out  ADDR_W  downstream address.
- pmem_wdata  out  LINE_W  downstream write line.
- grant_valid  out  1  a transaction is in flight.
- grant_idx  out  $clog2(NUM_PORTS)  index of the granted port; meaningful only while grant_valid = 1.

## Operation
- Port i requests when req_read[i] | req_write[i]. The requester holds read/write, address and wdata stable until it sees req_resp[i].
- Asserting both req_read[i] and req_write[i] is illegal. The arbiter forwards both bits unchanged.
- FSM states: IDLE and BUSY.
- IDLE: if any port requests, select a winner by POLICY, load grant_idx, and go to BUSY. Otherwise stay in IDLE.
- BUSY: pmem_read, pmem_write, pmem_address and pmem_wdata are combinationally muxed from port grant_idx. When pmem_resp = 1, req_resp[grant_idx] = 1 in the same cycle and the FSM returns to IDLE.
- Round-robin (POLICY = 0): register last_grant. Search from last_grant+1 upward, wrapping modulo NUM_PORTS. The first requesting port wins. last_grant <= winner on the grant edge.
- Fixed priority (POLICY = 1): the lowest requesting index wins. last_grant is unused.
- In IDLE all pmem_* outputs are 0. No downstream request is issued in the cycle a request first appears.
- req_rdata = pmem_rdata at all times. req_resp bits of non-granted ports are always 0.
- pmem_resp received in IDLE is ignored; no req_resp pulses.
- If the granted port drops its request while BUSY (protocol violation), the grant is held until pmem_resp. The pmem_* outputs follow the muxed, now-deasserted port signals.
- Reset values, applied immediately on rst assertion:
  - FSM = IDLE, last_grant = NUM_PORTS-1, grant_idx = 0.
  - All outputs 0.
  - An in-flight transaction is abandoned.

## Timing
- Grant latency: a request first visible in cycle k (FSM in IDLE) drives pmem_* from cycle k+1.
- A transaction occupies cycles k+1 through the pmem_resp cycle r inclusive. req_resp is a one-cycle pulse in cycle r.
- Back-to-back: the FSM is IDLE in cycle r+1 and may grant at the r+1 edge. The next port's pmem_* appear in cycle r+2.
- Minimum gap between downstream transactions is therefore one idle cycle.
- The requester that just completed must deassert its request in cycle r+1. Cache FSMs registering req_resp do this naturally, so the same port is never re-granted spuriously.
- grant_valid = (FSM == BUSY).

## Test plan
- Reset: assert rst mid-BUSY with pmem_read high -> all outputs drop to 0 in the same cycle. After release, a request on port 0 is granted with latency 1.
- Single read: port 1 reads 0x1230, pmem_resp in the 3rd BUSY cycle with rdata 0xDEAD…BEEF -> pmem_read = 1 and pmem_address = 0x1230 for 3 cycles, req_resp = 2'b10 for one cycle, req_rdata matches.
- Contention, POLICY = 0, NUM_PORTS = 2: both ports issue continuous back-to-back requests -> grants go 0, 1, 0, 1 with one idle cycle between each.
- Wrap, NUM_PORTS = 4, POLICY = 0: last_grant = 3, ports 0 and 2 request -> port 0 wins, then port 2.
- Fixed priority, POLICY = 1: port 0 re-requests on every idle cycle while port 1 waits -> port 0 wins every arbitration. Port 1 is granted once port 0 goes quiet.
- Write path: port 0 writes wdata 0x0123…CDEF to 0x0040 -> pmem_write = 1 with the matching wdata, pmem_read = 0, req_resp[0] pulses on pmem_resp.

Source files
------------

// File: rtl/pmem_arbiter_rr.sv
// N-port line-granular arbiter in front of a single physical-memory / L2 port.
// One transaction in flight at a time; round-robin or fixed-priority grant.
module pmem_arbiter_rr #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 16,
  parameter int LINE_W    = 128,
  parameter int POLICY    = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           req_read,
  input  logic [NUM_PORTS-1:0]           req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]    req_address,
  input  logic [NUM_PORTS*LINE_W-1:0]    req_wdata,
  output logic [NUM_PORTS-1:0]           req_resp,
  output logic [LINE_W-1:0]              req_rdata,
  input  logic                           pmem_resp,
  input  logic [LINE_W-1:0]              pmem_rdata,
  output logic                           pmem_read,
  output logic                           pmem_write,
  output logic [ADDR_W-1:0]              pmem_address,
  output logic [LINE_W-1:0]              pmem_wdata,
  output logic                           grant_valid,
  output logic [$clog2(NUM_PORTS)-1:0]   grant_idx
);
  localparam int IW = $clog2(NUM_PORTS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                           state, state_nxt;
  logic [IW-1:0]                    last_grant, winner, idx;
  logic [NUM_PORTS-1:0]             req;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_arr;
  logic [NUM_PORTS-1:0][LINE_W-1:0] wdata_arr;

  assign req         = req_read | req_write;
  assign addr_arr    = req_address;
  assign wdata_arr   = req_wdata;
  assign req_rdata   = pmem_rdata;
  assign grant_valid = (state == BUSY);

  // Scan from the far end toward the preferred port so the last hit is the winner.
  always_comb begin
    winner = '0;
    idx    = '0;
    if (POLICY == 1) begin
      for (int i = NUM_PORTS-1; i >= 0; i--) begin
        idx = IW'(i);
        if (req[idx]) winner = idx;
      end
    end else begin
      for (int off = NUM_PORTS; off >= 1; off--) begin
        idx = IW'((int'(last_grant) + off) % NUM_PORTS);
        if (req[idx]) winner = idx;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    req_resp     = '0;
    case (state)
      IDLE: if (|req) state_nxt = BUSY;
      BUSY: begin
        // Mux follows the granted port even if it drops its request early.
        pmem_read    = req_read[grant_idx];
        pmem_write   = req_write[grant_idx];
        pmem_address = addr_arr[grant_idx];
        pmem_wdata   = wdata_arr[grant_idx];
        if (pmem_resp) begin
          req_resp[grant_idx] = 1'b1;
          state_nxt           = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IW'(NUM_PORTS-1);
      grant_idx  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |req) begin
        grant_idx  <= winner;
        last_grant <= winner;
      end
    end
  end

endmodule

// File: tb/tb_pmem_arbiter_rr.sv
// Directed bench: cycle table on a 2-port round-robin instance, plus hand
// sequences for reset mid-transaction, 4-port wrap and fixed priority.
module tb_pmem_arbiter_rr;
  localparam int AW = 16;
  localparam int LW = 128;
  localparam logic [LW-1:0] WD0 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [LW-1:0] WD1 = 128'hFEDCBA9876543210FEDCBA9876543210;
  localparam logic [LW-1:0] RD  = 128'hDEADBEEF0011223344556677CAFEBEEF;

  logic clk = 1'b0;
  logic rst;
  logic [LW-1:0] pmem_rdata;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // 2-port round-robin
  logic [1:0] a_rd, a_wr, a_resp;
  logic [2*AW-1:0] a_addr;
  logic [2*LW-1:0] a_wd;
  logic a_presp, a_pr, a_pw, a_gv, a_gi;
  logic [AW-1:0] a_pa;
  logic [LW-1:0] a_pwd, a_rdata;

  // 4-port round-robin
  logic [3:0] b_rd, b_wr, b_resp;
  logic [4*AW-1:0] b_addr;
  logic [4*LW-1:0] b_wd;
  logic b_presp, b_pr, b_pw, b_gv;
  logic [1:0] b_gi;
  logic [AW-1:0] b_pa;
  logic [LW-1:0] b_pwd, b_rdata;

  // 2-port fixed priority
  logic [1:0] c_rd, c_wr, c_resp;
  logic [2*AW-1:0] c_addr;
  logic [2*LW-1:0] c_wd;
  logic c_presp, c_pr, c_pw, c_gv, c_gi;
  logic [AW-1:0] c_pa;
  logic [LW-1:0] c_pwd, c_rdata;

  pmem_arbiter_rr #(.NUM_PORTS(2), .ADDR_W(AW), .LINE_W(LW), .POLICY(0)) u_rr2 (
    .clk(clk), .rst(rst), .req_read(a_rd), .req_write(a_wr), .req_address(a_addr),
    .req_wdata(a_wd), .req_resp(a_resp), .req_rdata(a_rdata), .pmem_resp(a_presp),
    .pmem_rdata(pmem_rdata), .pmem_read(a_pr), .pmem_write(a_pw), .pmem_address(a_pa),
    .pmem_wdata(a_pwd), .grant_valid(a_gv), .grant_idx(a_gi));

  pmem_arbiter_rr #(.NUM_PORTS(4), .ADDR_W(AW), .LINE_W(LW), .POLICY(0)) u_rr4 (
    .clk(clk), .rst(rst), .req_read(b_rd), .req_write(b_wr), .req_address(b_addr),
    .req_wdata(b_wd), .req_resp(b_resp), .req_rdata(b_rdata), .pmem_resp(b_presp),
    .pmem_rdata(pmem_rdata), .pmem_read(b_pr), .pmem_write(b_pw), .pmem_address(b_pa),
    .pmem_wdata(b_pwd), .grant_valid(b_gv), .grant_idx(b_gi));

  pmem_arbiter_rr #(.NUM_PORTS(2), .ADDR_W(AW), .LINE_W(LW), .POLICY(1)) u_fix (
    .clk(clk), .rst(rst), .req_read(c_rd), .req_write(c_wr), .req_address(c_addr),
    .req_wdata(c_wd), .req_resp(c_resp), .req_rdata(c_rdata), .pmem_resp(c_presp),
    .pmem_rdata(pmem_rdata), .pmem_read(c_pr), .pmem_write(c_pw), .pmem_address(c_pa),
    .pmem_wdata(c_pwd), .grant_valid(c_gv), .grant_idx(c_gi));

  typedef struct {
    logic [1:0]    rd, wr;
    logic [AW-1:0] a0, a1;
    logic          presp;
    logic          pr, pw;
    logic [AW-1:0] pa;
    logic [1:0]    wd;    // 0: zero, 1: port 0 line, 2: port 1 line
    logic [1:0]    resp;
    logic          gv, gi;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(int rd, int wr, int a0, int a1, int presp,
                              int pr, int pw, int pa, int wd, int resp, int gv, int gi);
    vec_t v;
    v.rd = rd[1:0];   v.wr = wr[1:0];   v.a0 = a0[AW-1:0]; v.a1 = a1[AW-1:0];
    v.presp = presp[0]; v.pr = pr[0];   v.pw = pw[0];      v.pa = pa[AW-1:0];
    v.wd = wd[1:0];   v.resp = resp[1:0]; v.gv = gv[0];    v.gi = gi[0];
    return v;
  endfunction

  function automatic logic [LW-1:0] wd_of(input logic [1:0] code);
    return (code == 2'd1) ? WD0 : (code == 2'd2) ? WD1 : '0;
  endfunction

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          rd wr a0      a1      rsp  pr pw pa      wd resp gv gi
    tbl[0]  = mk(0, 0, 'h0A00, 'h1230, 0,  0, 0, 0,      0, 0,   0, 0);
    tbl[1]  = mk(2, 0, 'h0A00, 'h1230, 0,  0, 0, 0,      0, 0,   0, 0);
    tbl[2]  = mk(2, 0, 'h0A00, 'h1230, 0,  1, 0, 'h1230, 2, 0,   1, 1);
    tbl[3]  = mk(2, 0, 'h0A00, 'h1230, 0,  1, 0, 'h1230, 2, 0,   1, 1);
    tbl[4]  = mk(2, 0, 'h0A00, 'h1230, 1,  1, 0, 'h1230, 2, 2,   1, 1);
    tbl[5]  = mk(0, 0, 'h0A00, 'h0B00, 0,  0, 0, 0,      0, 0,   0, 0);
    tbl[6]  = mk(3, 0, 'h0A00, 'h0B00, 0,  0, 0, 0,      0, 0,   0, 0);
    tbl[7]  = mk(3, 0, 'h0A00, 'h0B00, 1,  1, 0, 'h0A00, 1, 1,   1, 0);
    tbl[8]  = mk(3, 0, 'h0A00, 'h0B00, 0,  0, 0, 0,      0, 0,   0, 0);
    tbl[9]  = mk(3, 0, 'h0A00, 'h0B00, 1,  1, 0, 'h0B00, 2, 2,   1, 1);
    tbl[10] = mk(3, 0, 'h0A00, 'h0B00, 0,  0, 0, 0,      0, 0,   0, 0);
    tbl[11] = mk(3, 0, 'h0A00, 'h0B00, 1,  1, 0, 'h0A00, 1, 1,   1, 0);
    tbl[12] = mk(0, 0, 'h0A00, 'h0B00, 0,  0, 0, 0,      0, 0,   0, 0);
    tbl[13] = mk(0, 1, 'h0040, 'h0B00, 0,  0, 0, 0,      0, 0,   0, 0);
    tbl[14] = mk(0, 1, 'h0040, 'h0B00, 0,  0, 1, 'h0040, 1, 0,   1, 0);
    tbl[15] = mk(0, 1, 'h0040, 'h0B00, 1,  0, 1, 'h0040, 1, 1,   1, 0);
    tbl[16] = mk(0, 0, 'h0040, 'h0B00, 0,  0, 0, 0,      0, 0,   0, 0);
    tbl[17] = mk(0, 0, 'h0040, 'h0B00, 1,  0, 0, 0,      0, 0,   0, 0);
    tbl[18] = mk(2, 0, 'h0A00, 'h0B00, 0,  0, 0, 0,      0, 0,   0, 0);
    tbl[19] = mk(0, 0, 'h0A00, 'h0B00, 0,  0, 0, 'h0B00, 2, 0,   1, 1);
    tbl[20] = mk(0, 0, 'h0A00, 'h0B00, 1,  0, 0, 'h0B00, 2, 2,   1, 1);
    tbl[21] = mk(0, 0, 'h0A00, 'h0B00, 0,  0, 0, 0,      0, 0,   0, 0);

    rst = 1'b1; pmem_rdata = RD;
    a_rd = '0; a_wr = '0; a_addr = '0; a_wd = {WD1, WD0}; a_presp = 1'b0;
    b_rd = '0; b_wr = '0; b_wd = '0; a_presp = 1'b0; b_presp = 1'b0;
    b_addr = {16'h0300, 16'h0200, 16'h0100, 16'h0000};
    c_rd = '0; c_wr = '0; c_addr = {16'h0B00, 16'h0A00}; c_wd = {WD1, WD0}; c_presp = 1'b0;

    repeat (2) tick();
    chk("reset.pmem_read",  LW'(a_pr),   0);
    chk("reset.pmem_write", LW'(a_pw),   0);
    chk("reset.pmem_addr",  LW'(a_pa),   0);
    chk("reset.req_resp",   LW'(a_resp), 0);
    chk("reset.grant_valid",LW'(a_gv),   0);
    chk("reset.grant_idx",  LW'(a_gi),   0);
    chk("reset.rr4.valid",  LW'(b_gv),   0);
    chk("reset.fix.valid",  LW'(c_gv),   0);
    @(negedge clk); rst = 1'b0;
    tick();

    for (int i = 0; i < 22; i++) begin
      a_rd = tbl[i].rd; a_wr = tbl[i].wr; a_addr = {tbl[i].a1, tbl[i].a0};
      a_presp = tbl[i].presp;
      @(negedge clk);
      chk($sformatf("v%0d.pmem_read", i),    LW'(a_pr),   LW'(tbl[i].pr));
      chk($sformatf("v%0d.pmem_write", i),   LW'(a_pw),   LW'(tbl[i].pw));
      chk($sformatf("v%0d.pmem_address", i), LW'(a_pa),   LW'(tbl[i].pa));
      chk($sformatf("v%0d.pmem_wdata", i),   a_pwd,       wd_of(tbl[i].wd));
      chk($sformatf("v%0d.req_resp", i),     LW'(a_resp), LW'(tbl[i].resp));
      chk($sformatf("v%0d.grant_valid", i),  LW'(a_gv),   LW'(tbl[i].gv));
      chk($sformatf("v%0d.req_rdata", i),    a_rdata,     RD);
      if (tbl[i].gv) chk($sformatf("v%0d.grant_idx", i), LW'(a_gi), LW'(tbl[i].gi));
      tick();
    end

    // Reset while BUSY, then a fresh grant with one-cycle latency.
    a_rd = 2'b01; a_wr = '0; a_addr = {16'h0B00, 16'h0100}; a_presp = 1'b0;
    tick();
    @(negedge clk);
    chk("rst.busy_before", LW'(a_pr), 1);
    rst = 1'b1; #1;
    chk("rst.pmem_read", LW'(a_pr), 0);
    chk("rst.pmem_addr", LW'(a_pa), 0);
    chk("rst.pmem_wdata", a_pwd, 0);
    chk("rst.grant_valid", LW'(a_gv), 0);
    tick();
    @(negedge clk); rst = 1'b0; #1;
    chk("rst.idle_after", LW'(a_pr), 0);
    tick();
    chk("rst.regrant_read", LW'(a_pr), 1);
    chk("rst.regrant_addr", LW'(a_pa), 'h0100);
    chk("rst.regrant_idx",  LW'(a_gi), 0);
    a_presp = 1'b1; #1;
    chk("rst.resp", LW'(a_resp), 1);
    tick();
    a_presp = 1'b0; a_rd = '0;
    chk("rst.back_idle", LW'(a_gv), 0);

    // 4-port wrap: last_grant = 3 after reset.
    b_rd = 4'b0101;
    @(negedge clk);
    chk("wrap.idle", LW'(b_gv), 0);
    tick();
    chk("wrap.g0.idx",  LW'(b_gi), 0);
    chk("wrap.g0.addr", LW'(b_pa), 'h0000);
    b_presp = 1'b1; #1;
    chk("wrap.g0.resp", LW'(b_resp), 'b0001);
    tick();
    b_presp = 1'b0; b_rd = 4'b0100;
    chk("wrap.gap", LW'(b_gv), 0);
    tick();
    chk("wrap.g2.idx",  LW'(b_gi), 2);
    chk("wrap.g2.addr", LW'(b_pa), 'h0200);
    b_presp = 1'b1; #1;
    chk("wrap.g2.resp", LW'(b_resp), 'b0100);
    tick();
    b_presp = 1'b0; b_rd = 4'b1010;
    tick();
    chk("wrap.g3.idx",  LW'(b_gi), 3);
    chk("wrap.g3.addr", LW'(b_pa), 'h0300);
    b_presp = 1'b1; #1;
    chk("wrap.g3.resp", LW'(b_resp), 'b1000);
    tick();
    b_presp = 1'b0; b_rd = 4'b0010;
    tick();
    chk("wrap.g1.idx", LW'(b_gi), 1);
    b_presp = 1'b1;
    tick();
    b_presp = 1'b0; b_rd = '0;

    // Fixed priority: port 0 keeps re-requesting and keeps winning.
    c_rd = 2'b11;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("fix.win%0d.idx", k),  LW'(c_gi), 0);
      chk($sformatf("fix.win%0d.addr", k), LW'(c_pa), 'h0A00);
      c_presp = 1'b1; #1;
      chk($sformatf("fix.win%0d.resp", k), LW'(c_resp), 'b01);
      tick();
      c_presp = 1'b0;
      if (k == 2) c_rd = 2'b10;
      chk($sformatf("fix.gap%0d", k), LW'(c_gv), 0);
      tick();
    end
    chk("fix.p1.idx",  LW'(c_gi), 1);
    chk("fix.p1.addr", LW'(c_pa), 'h0B00);
    c_presp = 1'b1; #1;
    chk("fix.p1.resp", LW'(c_resp), 'b10);
    tick();
    c_presp = 1'b0; c_rd = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
